// File: rtl/layer_mem_responder_pkg.sv
// Shared definitions for the layer-memory responder: bank select codes,
// default widths and per-layer bank depths.
package layer_mem_responder_pkg;

  localparam int DATA_WIDTH_DEF = 20;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int L0_DEPTH_DEF   = 4096;
  localparam int L1_DEPTH_DEF   = 1024;
  localparam int L2_DEPTH_DEF   = 2048;
  localparam int NUM_BANKS      = 5;

  typedef enum logic [2:0] {
    CSEL_NONE = 3'b000,
    CSEL_L0K0 = 3'b001,
    CSEL_L0K1 = 3'b010,
    CSEL_L1K0 = 3'b011,
    CSEL_L1K1 = 3'b100,
    CSEL_L2   = 3'b101
  } csel_e;

  // Bank k (0 = L0K0 ... 4 = L2) is selected by csel code k+1.
  function automatic logic [2:0] bank_csel(input int k);
    return 3'(k + 1);
  endfunction

endpackage

// File: rtl/layer_mem_responder_bank.sv
// One layer bank: synchronous write, read-first registered read, and a
// saturating count of accepted writes that drives the full flag.
module layer_bank
  import layer_mem_responder_pkg::*;
#(
  parameter int DEPTH      = L1_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [CW-1:0]         cnt_reg;

  // Write port; contents are deliberately not reset so the array maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (re) rdata_reg <= mem[raddr];
  end

  // Accepted-write counter, saturating at the bank depth (rewrites still count).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (we && (cnt_reg != DEPTH_CNT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign rdata = rdata_reg;
  assign full  = (cnt_reg == DEPTH_CNT);

endmodule

// File: rtl/layer_mem_responder.sv
// Responder for the convolution datapath's layer memory: decodes csel and
// address range, drives five layer banks, muxes read data and tracks errors.
module layer_mem_responder
  import layer_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int L0_DEPTH   = L0_DEPTH_DEF,
  parameter int L1_DEPTH   = L1_DEPTH_DEF,
  parameter int L2_DEPTH   = L2_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cwr,
  input  logic [ADDR_WIDTH-1:0] caddr_wr,
  input  logic [DATA_WIDTH-1:0] cdata_wr,
  input  logic                  crd,
  input  logic [ADDR_WIDTH-1:0] caddr_rd,
  input  logic [2:0]            csel,
  output logic [DATA_WIDTH-1:0] cdata_rd,
  output logic                  rd_valid,
  output logic                  err,
  output logic [NUM_BANKS-1:0]  bank_full
);

  logic [NUM_BANKS-1:0]  wr_hit;
  logic [NUM_BANKS-1:0]  rd_hit;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [2:0]            rd_src_reg;
  logic                  rd_valid_reg;
  logic                  err_reg;
  logic                  wr_bad;
  logic                  rd_bad;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam int D  = (gi < 2) ? L0_DEPTH : (gi < 4) ? L1_DEPTH : L2_DEPTH;
      localparam int AW = $clog2(D);
      localparam logic [31:0] D_U = 32'(D);

      logic sel;
      assign sel        = (csel == bank_csel(gi));
      assign wr_hit[gi] = sel && (32'(caddr_wr) < D_U);
      assign rd_hit[gi] = sel && (32'(caddr_rd) < D_U);

      layer_bank #(
        .DEPTH      (D),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
      ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (reset_n && cwr && wr_hit[gi]),
        .waddr   (caddr_wr[AW-1:0]),
        .wdata   (cdata_wr),
        .re      (reset_n && crd && rd_hit[gi]),
        .raddr   (caddr_rd[AW-1:0]),
        .rdata   (bank_rdata[gi]),
        .full    (bank_full[gi])
      );
    end
  endgenerate

  // A strobe is bad when no bank claims it (bad select or address out of range).
  assign wr_bad = cwr && !(|wr_hit);
  assign rd_bad = crd && !(|rd_hit);

  // Read-source select, read-valid pulse and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_src_reg   <= CSEL_NONE;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= crd;
      if (crd) rd_src_reg <= (|rd_hit) ? csel : CSEL_NONE;
      if (wr_bad || rd_bad) err_reg <= 1'b1;
    end
  end

  // Read-data mux; a rejected read (source NONE) returns zero.
  always_comb begin
    cdata_rd = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (rd_src_reg == bank_csel(k)) cdata_rd = bank_rdata[k];
    end
  end

  assign rd_valid = rd_valid_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_layer_mem_responder.sv
// Scoreboard bench for layer_mem_responder: a driver updates a behavioural
// memory model and queues expected reads; a negedge monitor checks responses.
module tb_layer_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;
  logic [19:0] cdata_rd;
  logic        rd_valid;
  logic        err;
  logic [4:0]  bank_full;

  layer_mem_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cwr       (cwr),
    .caddr_wr  (caddr_wr),
    .cdata_wr  (cdata_wr),
    .crd       (crd),
    .caddr_rd  (caddr_rd),
    .csel      (csel),
    .cdata_rd  (cdata_rd),
    .rd_valid  (rd_valid),
    .err       (err),
    .bank_full (bank_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [19:0] data;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] mem_m   [5][4096];
  bit          known_m [5][4096];
  int          cnt_m   [5];
  bit          err_m;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          rst_edge = 1'b0;
  logic [19:0] last_exp = '0;
  bit          last_known = 1'b1;

  function automatic int depth_m(input int k);
    return (k < 2) ? 4096 : (k < 4) ? 1024 : 2048;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_edge = reset_n;
  end

  // Monitor: pop and compare whenever the DUT presents read data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_edge) begin
      sb.delete();
      check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("reset_cdata_rd", {12'd0, cdata_rd}, 32'd0);
      last_exp   = '0;
      last_known = 1'b1;
    end else if (rd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_latency", cyc, e.due);
        if (e.chk) check("rd_data", {12'd0, cdata_rd}, {12'd0, e.data});
        last_exp   = e.data;
        last_known = e.chk;
      end
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("rd_valid_missing", {31'd0, rd_valid}, 32'd1);
        last_known = 1'b0;
      end
      if (last_known) check("cdata_rd_hold", {12'd0, cdata_rd}, {12'd0, last_exp});
    end
  end

  // Drive one cycle of stimulus, update the model, then check status flags.
  task automatic do_cycle(input bit w, input bit r, input logic [2:0] sel,
                          input logic [11:0] wa, input logic [19:0] wd, input logic [11:0] ra);
    int         k;
    bit         vs;
    exp_t       e;
    logic [4:0] full_exp;
    cwr = w; crd = r; csel = sel; caddr_wr = wa; cdata_wr = wd; caddr_rd = ra;
    vs = (sel >= 3'd1) && (sel <= 3'd5);
    k  = vs ? int'(sel) - 1 : 0;
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) cnt_m[i] = 0;
      err_m = 1'b0;
    end else begin
      if (r) begin
        e.due = cyc + 1;
        if (vs && int'(ra) < depth_m(k)) begin
          e.data = mem_m[k][ra];
          e.chk  = known_m[k][ra];
        end else begin
          e.data = '0;
          e.chk  = 1'b1;
          err_m  = 1'b1;
        end
        sb.push_back(e);
      end
      if (w) begin
        if (vs && int'(wa) < depth_m(k)) begin
          mem_m[k][wa]   = wd;
          known_m[k][wa] = 1'b1;
          if (cnt_m[k] < depth_m(k)) cnt_m[k]++;
        end else begin
          err_m = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("err", {31'd0, err}, {31'd0, err_m});
    for (int i = 0; i < 5; i++) full_exp[i] = (cnt_m[i] == depth_m(i));
    check("bank_full", {27'd0, bank_full}, {27'd0, full_exp});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 3'd0, 12'd0, 20'd0, 12'd0);
  endtask

  initial begin
    for (int b = 0; b < 5; b++) begin
      cnt_m[b] = 0;
      for (int a = 0; a < 4096; a++) begin
        mem_m[b][a]   = '0;
        known_m[b][a] = 1'b0;
      end
    end
    err_m   = 1'b0;
    reset_n = 1'b0;
    cwr = 0; crd = 0; csel = 0; caddr_wr = 0; cdata_wr = 0; caddr_rd = 0;
    @(posedge clk);
    #1;
    idle(3);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_bank_full", {27'd0, bank_full}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Write then read back L0K0 address 5.
    do_cycle(1, 0, 3'd1, 12'd5, 20'h0ABCD, 12'd0);
    do_cycle(0, 1, 3'd1, 12'd0, 20'd0, 12'd5);
    idle(1);

    // Read-first collision on L1K1 address 7.
    do_cycle(1, 0, 3'd4, 12'd7, 20'h00111, 12'd0);
    do_cycle(1, 1, 3'd4, 12'd7, 20'h12345, 12'd7);
    do_cycle(0, 1, 3'd4, 12'd0, 20'd0, 12'd7);
    idle(1);

    // L2 addresses 0..3 hold 1..4, then read back-to-back.
    for (int i = 0; i < 4; i++) do_cycle(1, 0, 3'd5, 12'(i), 20'(i + 1), 12'd0);
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 3'd5, 12'd0, 20'd0, 12'(i));
    idle(1);

    // Fill L1K0 with 1024 consecutive writes.
    for (int i = 0; i < 1024; i++) do_cycle(1, 0, 3'd3, 12'(i), 20'($urandom), 12'd0);
    check("l1k0_full", {27'd0, bank_full}, 32'b00100);
    idle(1);

    // Random legal traffic: valid selects, in-range addresses.
    for (int i = 0; i < 1500; i++)
      do_cycle(1'($urandom), 1'($urandom), 3'($urandom_range(1, 5)),
               12'($urandom_range(0, 63)), 20'($urandom), 12'($urandom_range(0, 63)));
    idle(1);

    // Invalid select read, then out-of-range L1K1 write.
    do_cycle(0, 1, 3'b110, 12'd0, 20'd0, 12'd3);
    do_cycle(1, 0, 3'd4, 12'd1024, 20'hFFFFF, 12'd0);
    idle(2);

    // Random traffic including illegal selects and out-of-range addresses.
    for (int i = 0; i < 1000; i++)
      do_cycle(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 63)) : 12'($urandom),
               20'($urandom),
               ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 63)) : 12'($urandom));

    // Fill L1K1 to depth; status is checked every cycle against the model count.
    for (int i = 0; i < 1100 && cnt_m[3] < 1024; i++)
      do_cycle(1, 0, 3'd4, 12'(i % 1024), 20'($urandom), 12'd0);
    idle(1);

    // Reset in the middle of an L2 write burst with a read just before reset.
    for (int i = 0; i < 4; i++) do_cycle(1, 0, 3'd5, 12'(100 + i), 20'(i + 16'h100), 12'd0);
    do_cycle(1, 1, 3'd5, 12'd104, 20'h00777, 12'd1);
    reset_n = 1'b0;
    do_cycle(1, 1, 3'd5, 12'd0, 20'hFFFFF, 12'd2);
    do_cycle(1, 0, 3'd5, 12'd1, 20'hEEEEE, 12'd0);
    reset_n = 1'b1;
    idle(1);
    for (int i = 0; i < 2; i++) do_cycle(0, 1, 3'd5, 12'd0, 20'd0, 12'(i));
    for (int i = 0; i < 5; i++) do_cycle(0, 1, 3'd5, 12'd0, 20'd0, 12'(100 + i));
    idle(3);
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_mem_responder.md
# layer_mem_responder

Responder end of the layer-memory interface driven by the convolution datapath. It decodes `csel` and services `cwr`/`crd` strobes against five internal banks: layer-0 kernel-0, layer-0 kernel-1, layer-1 kernel-0, layer-1 kernel-1, and layer-2 flat. It returns registered read data, flags protocol errors, and reports per-bank fill status so the controller can sequence the conv, pool and flatten phases.

## Interface
Parameters:
- `DATA_WIDTH`, 20, word width of every bank.
- `ADDR_WIDTH`, 12, width of `caddr_wr`/`caddr_rd`.
- `L0_DEPTH`, 4096, words per layer-0 bank.
- `L1_DEPTH`, 1024, words per layer-1 bank.
- `L2_DEPTH`, 2048, words in the layer-2 bank.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cwr`  in  1  write strobe.
- `caddr_wr`  in  ADDR_WIDTH  write address.
- `cdata_wr`  in  DATA_WIDTH  write data.
- `crd`  in  1  read strobe.
- `caddr_rd`  in  ADDR_WIDTH  read address.
- `csel`  in  3  bank select, shared by read and write: 001 L0K0, 010 L0K1, 011 L1K0, 100 L1K1, 101 L2.
- `cdata_rd`  out  DATA_WIDTH  registered read data.
- `rd_valid`  out  1  one-cycle pulse; `cdata_rd` is updated this cycle.
- `err`  out  1  sticky protocol-error flag.
- `bank_full`  out  5  bit k set once bank k (bit 0 = L0K0 … bit 4 = L2) has accepted `depth` writes.

## Operation
- **Write:** when `cwr`=1 with a valid `csel` and `caddr_wr` < that bank's depth, `mem[caddr_wr] <= cdata_wr` and that bank's write counter increments. The counter saturates at the bank depth. Rewrites of the same address still count.
- **Read:** when `crd`=1 with a valid `csel` and address in range, `cdata_rd <= mem[caddr_rd]` and `rd_valid <= 1`.
- **Simultaneous read and write:** `cwr` and `crd` may both be asserted in one cycle; both target the `csel` bank. On an address collision the read returns the old data (read-first).
- **Invalid select:** `csel` ∈ {000, 110, 111} with any strobe:
  - write dropped;
  - a read yields `cdata_rd`=0 with `rd_valid`=1;
  - `err` set.
- **Out-of-range address:** (e.g. L1 address ≥ 1024) same handling as invalid select: write dropped, read returns 0 with `rd_valid`=1, `err` set.
- **Idle:** no strobe means no state change; `cdata_rd` holds its last value and `rd_valid`=0.
- **Fill status:** `bank_full[k]` = (counter_k == depth_k). It rises in the cycle after the depth-th accepted write and stays set until reset.
- **Memory contents** are not reset. Contents before the first write are unspecified, and the bench must not check them.

## Timing
- Read latency is 1 cycle: a strobe at edge N gives `cdata_rd`/`rd_valid` visible after edge N+1.
- Full read throughput: one read per cycle, back-to-back, no stalls. Writes are also one per cycle.
- `err` asserts the cycle after the offending strobe and stays set until reset.
- Reset values:
  - `cdata_rd`=0, `rd_valid`=0, `err`=0, `bank_full`=0;
  - all counters 0.
- Reset asserted mid-operation: strobes sampled with `reset_n`=0 are ignored entirely (no memory write, no counter change). A read issued the cycle before reset does not produce `rd_valid` after reset.

## Structure
- Shared package holds:
  - `csel` encodings (`CSEL_L0K0`…`CSEL_L2`);
  - bank depth constants;
  - `DATA_WIDTH`/`ADDR_WIDTH` defaults.
  The datapath and the controller import the same package.
- One sub-module, `layer_bank`, parameterised by `DEPTH`, is instantiated five times. It contains:
  - the synchronous write;
  - the read-first registered read;
  - the saturating write counter;
  - the full flag.
- Top level does `csel`/range decode, error tracking and the read-data mux.

## Test plan
- Write 0x0ABCD to L0K0 address 5, read L0K0 address 5 next cycle → `rd_valid` pulses, `cdata_rd`=0x0ABCD one cycle after `crd`.
- Same cycle: `cwr` writes 0x12345 and `crd` reads L1K1 address 7, which previously held 0x00111 → read returns 0x00111; a later read returns 0x12345.
- Write 1024 consecutive addresses to L1K0 → `bank_full`=5'b00100 exactly one cycle after the 1024th write; other bits stay 0.
- `crd` with `csel`=110, then `cwr` to L1K1 address 1024 → `cdata_rd`=0, `rd_valid`=1, `err`=1 and stays set; L1K1 counter unchanged.
- Back-to-back reads of L2 addresses 0..3 pre-written with 1..4 → `cdata_rd` shows 1,2,3,4 on consecutive cycles with `rd_valid` high throughout.
- Assert `reset_n`=0 during a write burst → no writes land while in reset; all outputs and `bank_full` return to 0 on the next edge.
